// File: rtl/blit_pkg.sv
// Shared definitions for the blitter command queue: command width, opcode
// encodings, CPU register offsets and STATUS register bit positions.
package blit_pkg;

    localparam int CMD_W = 104;

    // Opcode carried in bits 103:96 of every queued command
    typedef enum logic [7:0] {
        OP_SET_DEST_ADDR = 8'h01,
        OP_SET_SRC_ADDR  = 8'h02,
        OP_SET_SIZE      = 8'h03,
        OP_SET_FG_COLOR  = 8'h04,
        OP_SET_BG_COLOR  = 8'h05,
        OP_SET_ROP       = 8'h06,
        OP_FILL_RECT     = 8'h07,
        OP_COPY_RECT     = 8'h08,
        OP_DRAW_PIXEL    = 8'h09,
        OP_DRAW_LINE     = 8'h0A
    } blit_op_e;

    // CPU word offsets
    localparam logic [2:0] REG_DATA0  = 3'd0;
    localparam logic [2:0] REG_DATA1  = 3'd1;
    localparam logic [2:0] REG_DATA2  = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // STATUS register layout
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_IRQ_BIT   = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_FREE_LSB  = 16;

endpackage

// File: rtl/blit_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented combinationally
// from the storage array so a pop exposes the next entry with no bubble.
// The head is forced to zero while empty so stale storage never leaks out.
module blit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 104
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO can still accept a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; data only, no reset needed
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blit_cmd_queue.sv
// CPU-side front end of the blitter. Three staging words plus an opcode
// write form a 104-bit command which is pushed into a show-ahead FIFO whose
// head feeds the blitter command stage. STATUS reports fill level and busy.
// Optional idle interrupt: define BLIT_QUEUE_IRQ_EN to build the pending
// flag that sets when the engine goes idle and clears on a STATUS read.
module blit_cmd_queue
    import blit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              cpu_write,
    input  logic              cpu_read,
    input  logic [2:0]        cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [CMD_W-1:0]  p0_cmd,
    output logic              p0_cmd_valid,
    input  logic              cmd_next,
    input  logic              blit_active,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]      data0;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic             pop_ok;
    logic             cmd_wr;
    logic             cmd_blocked;
    logic             push;
    logic [CMD_W-1:0] push_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             busy;
    logic [8:0]       count9;
    logic [7:0]       count8;
    logic [15:0]      free16;
    logic             irq_pending;
    logic [31:0]      status_word;
    logic [31:0]      rd_mux;

    // The consumer may only take the head when one exists and the pipe is moving
    assign pop_ok      = cmd_next & ~stall & p0_cmd_valid;
    assign cmd_wr      = cpu_write & (cpu_addr == REG_CMD);
    assign cmd_blocked = cmd_wr & full & ~pop_ok;
    assign cpu_ready   = ~cmd_blocked;
    assign push        = cmd_wr & ~cmd_blocked;
    assign push_data   = {cpu_wdata[7:0], data2, data1, data0};

    blit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_ok),
        .head      (p0_cmd),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign p0_cmd_valid = ~empty;
    assign busy         = p0_cmd_valid | blit_active;

    // The 8-bit count field saturates so DEPTH=256 reads as 255
    assign count9 = 9'(count);
    assign count8 = count9[8] ? 8'hFF : count9[7:0];
    assign free16 = 16'(DEPTH) - 16'(count);

`ifdef BLIT_QUEUE_IRQ_EN
    logic busy_q;
    logic status_rd;

    assign status_rd = cpu_read & (cpu_addr == REG_STATUS);

    // Idle detect: set on busy falling edge, cleared by a STATUS read (set wins)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            busy_q <= busy;
            if (busy_q & ~busy) begin
                irq_pending <= 1'b1;
            end else if (status_rd) begin
                irq_pending <= 1'b0;
            end
        end
    end

    assign irq = irq_pending;
`else
    assign irq_pending = 1'b0;
    assign irq         = 1'b0;
`endif

    // Staging words persist across pushes so only changed words need rewriting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data0 <= '0;
            data1 <= '0;
            data2 <= '0;
        end else if (cpu_write) begin
            case (cpu_addr)
                REG_DATA0: data0 <= cpu_wdata;
                REG_DATA1: data1 <= cpu_wdata;
                REG_DATA2: data2 <= cpu_wdata;
                default:   ;
            endcase
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word                            = '0;
        status_word[ST_BUSY_BIT]               = busy;
        status_word[ST_FULL_BIT]               = full;
        status_word[ST_IRQ_BIT]                = irq_pending;
        status_word[ST_COUNT_LSB +: 8]         = count8;
        status_word[ST_FREE_LSB +: 16]         = free16;
    end

    // Read data selection; CMD and unmapped offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            REG_DATA0:  rd_mux = data0;
            REG_DATA1:  rd_mux = data1;
            REG_DATA2:  rd_mux = data2;
            REG_STATUS: rd_mux = status_word;
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata <= '0;
        end else if (cpu_read) begin
            cpu_rdata <= rd_mux;
        end
    end

endmodule
